// File: rtl/sram_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_sync_if
// Brief    : Access bus for sram_sync (select/strobes/address/data, read
//            return and initialisation busy flag).
// Revision : 1.0 - initial release
// ============================================================================
interface sram_sync_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          cs;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          rvalid;
    logic          busy;

    modport master (
        output cs,
        output wr,
        output rd,
        output addr,
        output din,
        input  dout,
        input  rvalid,
        input  busy
    );

    modport slave (
        input  cs,
        input  wr,
        input  rd,
        input  addr,
        input  din,
        output dout,
        output rvalid,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/sram_sync.sv
`default_nettype none
// ============================================================================
// Module   : sram_sync
// Brief    : Single-port synchronous SRAM, 2^AW x DW, self-clearing after reset.
//            Macro SRAM_WR_BYPASS_EN selects write-first same-cycle wr+rd
//            (default is read-first).
// Revision : 1.0 - initial release
// ============================================================================
module sram_sync #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    sram_sync_if.slave  bus
);

    localparam int         c_DEPTH   = 1 << AW;
    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_IDLE = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_init_cnt;
    logic [DW-1:0] r_mem [c_DEPTH];
    logic [DW-1:0] r_dout;
    logic          r_rvalid;

    logic          w_idle;
    logic          w_acc_wr;
    logic          w_acc_rd;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] w_rd_data;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_acc_wr = w_idle & bus.cs & bus.wr;
    assign w_acc_rd = w_idle & bus.cs & bus.rd;

    // The clear sweep and user writes share the single write port; nothing is
    // written while reset is held so the array is only cleared by the sweep.
    assign w_mem_we    = rst_n & (~w_idle | w_acc_wr);
    assign w_mem_addr  = w_idle ? bus.addr : r_init_cnt;
    assign w_mem_wdata = w_idle ? bus.din  : '0;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_INIT;
            r_init_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == {AW{1'b1}}) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_WR_BYPASS_EN
    assign w_rd_data = w_acc_wr ? bus.din : r_mem[bus.addr];
`else
    assign w_rd_data = r_mem[bus.addr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_acc_rd;
            if (w_acc_rd) begin
                r_dout <= w_rd_data;
            end
        end
    end

    assign bus.dout   = r_dout;
    assign bus.rvalid = r_rvalid;
    assign bus.busy   = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_sram_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_sync
// Brief    : Directed vector bench for sram_sync (DW=8, AW=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_sync;

    typedef struct {
        logic       cs;
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] din;
        logic       exp_rvalid;
        logic [7:0] exp_dout;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    vec_t vecs[$];

    sram_sync_if #(.DW(8), .AW(8)) bus ();

    sram_sync #(.DW(8), .AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic wr, input logic rd,
                         input logic [7:0] addr, input logic [7:0] din);
        bus.cs   = cs;
        bus.wr   = wr;
        bus.rd   = rd;
        bus.addr = addr;
        bus.din  = din;
    endtask

    task automatic add(input logic cs, input logic wr, input logic rd, input logic [7:0] addr,
                       input logic [7:0] din, input logic exp_rvalid, input logic [7:0] exp_dout);
        vec_t v;
        v.cs = cs; v.wr = wr; v.rd = rd; v.addr = addr; v.din = din;
        v.exp_rvalid = exp_rvalid; v.exp_dout = exp_dout;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops; returns 0 if busy was already low.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 1000) begin
            tick();
            cnt++;
        end
    endtask

    int  busy_cnt;
    logic saw_rvalid;
    logic [7:0] exp_same;

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef SRAM_WR_BYPASS_EN
        exp_same = 8'h3C;
`else
        exp_same = 8'h5B;
`endif
        //   cs wr rd addr   din    rv  dout
        add(1, 0, 1, 8'hAC, 8'h00, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        add(1, 1, 0, 8'hAC, 8'h5B, 0, 8'h00);
        add(1, 0, 1, 8'hAC, 8'h00, 1, 8'h5B);
        add(0, 0, 0, 8'h00, 8'h00, 0, 8'h5B);
        add(0, 1, 0, 8'h3A, 8'h5B, 0, 8'h5B);
        add(1, 0, 1, 8'h3A, 8'h00, 1, 8'h00);
        add(0, 0, 1, 8'hAC, 8'h00, 0, 8'h00);
        add(1, 0, 1, 8'h10, 8'h00, 1, 8'h00);
        add(1, 1, 1, 8'hAC, 8'h3C, 1, exp_same);
        add(0, 0, 0, 8'h00, 8'h00, 0, exp_same);
        add(1, 0, 1, 8'hAC, 8'h00, 1, 8'h3C);
        add(1, 1, 0, 8'h00, 8'h11, 0, 8'h3C);
        add(1, 1, 0, 8'h01, 8'h22, 0, 8'h3C);
        add(1, 1, 0, 8'h02, 8'h33, 0, 8'h3C);
        add(1, 1, 0, 8'h03, 8'h44, 0, 8'h3C);
        add(1, 0, 1, 8'h00, 8'h00, 1, 8'h11);
        add(1, 0, 1, 8'h01, 8'h00, 1, 8'h22);
        add(1, 0, 1, 8'h02, 8'h00, 1, 8'h33);
        add(1, 0, 1, 8'h03, 8'h00, 1, 8'h44);
        add(0, 0, 0, 8'h00, 8'h00, 0, 8'h44);
        add(1, 1, 0, 8'hFF, 8'hA5, 0, 8'h44);
        add(1, 0, 1, 8'hFF, 8'h00, 1, 8'hA5);

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        check("reset_dout", {24'd0, bus.dout}, 32'h00);
        check("reset_rvalid", {31'd0, bus.rvalid}, 32'h0);
        check("reset_busy", {31'd0, bus.busy}, 32'h1);
        tick();
        tick();
        rst_n = 1'b1;

        // Run 100 INIT cycles with a write+read that must be dropped
        drive(1'b1, 1'b1, 1'b1, 8'h10, 8'h77);
        saw_rvalid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.rvalid !== 1'b0 || bus.busy !== 1'b1) saw_rvalid = 1'b1;
        end
        check("busy_first_100", {31'd0, saw_rvalid}, 32'h0);

        // Reset mid-INIT for 2 cycles: full 256-cycle clear must follow
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        count_busy(busy_cnt);
        check("busy_cycles_after_reinit", busy_cnt, 256);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("rvalid_after_init", {31'd0, bus.rvalid}, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
            tick();
            check($sformatf("vec%0d_rvalid", i), {31'd0, bus.rvalid}, {31'd0, vecs[i].exp_rvalid});
            check($sformatf("vec%0d_dout", i), {24'd0, bus.dout}, {24'd0, vecs[i].exp_dout});
            check($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, 32'h0);
        end

        // Reset arriving with a read pending: no rvalid, dout cleared
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        check("midread_rvalid_async", {31'd0, bus.rvalid}, 32'h0);
        check("midread_dout_async", {24'd0, bus.dout}, 32'h00);
        tick();
        check("midread_rvalid_edge", {31'd0, bus.rvalid}, 32'h0);
        rst_n = 1'b1;
        count_busy(busy_cnt);
        check("busy_cycles_after_midread", busy_cnt, 256);
        check("midread_no_rvalid_during_init", {31'd0, bus.rvalid}, 32'h0);
        tick();
        check("cleared_ff_rvalid", {31'd0, bus.rvalid}, 32'h1);
        check("cleared_ff_dout", {24'd0, bus.dout}, 32'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check("rvalid_single_pulse", {31'd0, bus.rvalid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
